mux_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the team's 4:1 single-bit mux among four requesters. Each requester i drives a request bit req[i] and a data bit d[i]. The block decides which requester owns the mux, drives the 2-bit select, and exposes the selected bit with a valid flag. It bounds how long one requester may hold the mux while others wait, so no requester starves.

---
 rtl/mux_arb_pkg.sv | 44 ++++
 rtl/mux_rr_arbiter_mux4.sv | 15 +
 rtl/mux_rr_arbiter.sv | 126 ++++++++++++
 tb/tb_mux_rr_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter.
//   arb_state_t : arbiter state (IDLE, GRANT)
//   pick_t      : result of a round-robin search (found flag + index)
//   rr_pick     : first requester set in (req & ~excl), scanning ptr, ptr+1, ... mod N_REQ
//   onehot      : index -> one-hot grant vector
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                      input logic [SEL_W-1:0] ptr,
                                      input logic [N_REQ-1:0] excl);
        pick_t            p;
        logic [N_REQ-1:0] cand;
        logic [SEL_W-1:0] k;
        p    = '0;
        cand = req & ~excl;
        // Scan from the farthest offset down so the nearest candidate to ptr wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            k = ptr + SEL_W'(i);
            if (cand[k]) begin
                p.found = 1'b1;
                p.idx   = k;
            end
        end
        return p;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux4.sv
// Team 4:1 single-bit mux.
//   s : select index
//   d : data inputs
//   y : d[s]
module mux_rr_arbiter_mux4 (
    input  logic [1:0] s,
    input  logic [3:0] d,
    output logic       y
);

    always_comb begin
        y = d[s];
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing the 4:1 mux among four requesters.
// A requester keeps the mux until it drops its request, or until it has held
// it MAX_HOLD consecutive cycles while someone else is waiting.
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   req     : level request per requester
//   d       : data bit per requester
//   s       : registered select (current owner)
//   gnt     : registered one-hot grant, zero when idle
//   y       : d[s] gated by y_valid
//   y_valid : high while a grant is held
//
// state | meaning
// IDLE  | no owner, gnt=0, waiting for any request
// GRANT | owner s holds the mux, hold_cnt counts its consecutive cycles
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] d,
    output logic [SEL_W-1:0] s,
    output logic [N_REQ-1:0] gnt,
    output logic             y,
    output logic             y_valid
);

    localparam logic [3:0] LP_MAX = 4'(MAX_HOLD);

    arb_state_t       r_state, w_nxt_state;
    logic [SEL_W-1:0] r_s, w_nxt_s;
    logic [N_REQ-1:0] r_gnt, w_nxt_gnt;
    logic [SEL_W-1:0] r_ptr, w_nxt_ptr;
    logic [3:0]       r_hold, w_nxt_hold;

    logic [N_REQ-1:0] w_owner_mask;
    logic [SEL_W-1:0] w_after_owner;
    logic             w_any_other;
    pick_t            w_pick_idle;
    pick_t            w_pick_rot;
    logic             w_mux_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_gnt   <= '0;
            r_ptr   <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_s     <= w_nxt_s;
            r_gnt   <= w_nxt_gnt;
            r_ptr   <= w_nxt_ptr;
            r_hold  <= w_nxt_hold;
        end
    end

    always_comb begin
        w_owner_mask  = onehot(r_s);
        w_after_owner = r_s + SEL_W'(1);
        w_any_other   = |(req & ~w_owner_mask);
        w_pick_idle   = rr_pick(req, r_ptr, '0);
        w_pick_rot    = rr_pick(req, w_after_owner, w_owner_mask);
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_s     = r_s;
        w_nxt_gnt   = r_gnt;
        w_nxt_ptr   = r_ptr;
        w_nxt_hold  = r_hold;
        case (r_state)
            IDLE: begin
                if (w_pick_idle.found) begin
                    w_nxt_state = GRANT;
                    w_nxt_s     = w_pick_idle.idx;
                    w_nxt_gnt   = onehot(w_pick_idle.idx);
                    w_nxt_hold  = 4'd1;
                end
            end
            GRANT: begin
                if (!req[r_s]) begin
                    // Release: hand over directly when someone else waits.
                    w_nxt_ptr = w_after_owner;
                    if (w_any_other) begin
                        w_nxt_s    = w_pick_rot.idx;
                        w_nxt_gnt  = onehot(w_pick_rot.idx);
                        w_nxt_hold = 4'd1;
                    end else begin
                        w_nxt_state = IDLE;
                        w_nxt_gnt   = '0;
                    end
                end else if (r_hold == LP_MAX && w_any_other) begin
                    w_nxt_ptr  = w_after_owner;
                    w_nxt_s    = w_pick_rot.idx;
                    w_nxt_gnt  = onehot(w_pick_rot.idx);
                    w_nxt_hold = 4'd1;
                end else if (!w_any_other) begin
                    w_nxt_hold = (r_hold >= LP_MAX) ? LP_MAX : r_hold + 4'd1;
                end else begin
                    w_nxt_hold = r_hold + 4'd1;
                end
            end
            default: begin
                w_nxt_state = IDLE;
                w_nxt_gnt   = '0;
            end
        endcase
    end

    mux_rr_arbiter_mux4 u_mux (
        .s (r_s),
        .d (d),
        .y (w_mux_y)
    );

    assign s       = r_s;
    assign gnt     = r_gnt;
    assign y_valid = (r_state == GRANT);
    assign y       = w_mux_y & y_valid;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] d;
    logic [1:0] s;
    logic [3:0] gnt;
    logic       y;
    logic       y_valid;

    int n_checks = 0;
    int n_fail   = 0;

    mux_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .d       (d),
        .s       (s),
        .gnt     (gnt),
        .y       (y),
        .y_valid (y_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic expect_grant(input string tag, input logic [1:0] idx, input logic ey);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        check({tag, ".gnt"}, gnt, oh);
        check({tag, ".s"}, {2'b00, s}, {2'b00, idx});
        check({tag, ".y_valid"}, {3'b000, y_valid}, 4'b0001);
        check({tag, ".y"}, {3'b000, y}, {3'b000, ey});
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".gnt"}, gnt, 4'b0000);
        check({tag, ".y_valid"}, {3'b000, y_valid}, 4'b0000);
        check({tag, ".y"}, {3'b000, y}, 4'b0000);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b1111;
        d   = 4'b1111;

        // Reset held two cycles with all requests high.
        tick();
        expect_idle("rst_c1");
        check("rst_c1.s", {2'b00, s}, 4'b0000);
        tick();
        expect_idle("rst_c2");
        check("rst_c2.s", {2'b00, s}, 4'b0000);
        rst = 1'b0;
        #1;
        expect_idle("rst_rel");
        tick();
        expect_grant("rst_first", 2'd0, 1'b1);

        // Single requester never rotates; hold count saturates.
        do_reset();
        req = 4'b0100;
        d   = 4'b0100;
        tick();
        expect_grant("single_grant", 2'd2, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("single_hold.gnt", gnt, 4'b0100);
        end

        // Fairness: all requesting, each owner exactly 4 cycles.
        do_reset();
        req = 4'b1111;
        d   = 4'b0101;
        for (int k = 0; k < 17; k++) begin
            logic [1:0] own;
            tick();
            own = 2'((k / 4) % 4);
            expect_grant("fair", own, d[own]);
        end

        // Release handover: owner 1 drops with 0 and 3 waiting.
        do_reset();
        req = 4'b0010;
        d   = 4'b0000;
        tick();
        expect_grant("rel_own1", 2'd1, 1'b0);
        req = 4'b1001;
        tick();
        expect_grant("rel_to3", 2'd3, 1'b0);
        // Combinational data path: d[s] visible without a clock edge.
        d = 4'b1000;
        #1;
        check("rel_comb_y1", {3'b000, y}, 4'b0001);
        d = 4'b0111;
        #1;
        check("rel_comb_y0", {3'b000, y}, 4'b0000);
        req = 4'b0001;
        d   = 4'b0001;
        tick();
        expect_grant("rel_to0", 2'd0, 1'b1);

        // Wrap and idle: owner 3 releases with nothing pending.
        do_reset();
        req = 4'b0100;
        tick();
        expect_grant("wrap_own2", 2'd2, 1'b0);
        req = 4'b1000;
        d   = 4'b1000;
        tick();
        expect_grant("wrap_own3", 2'd3, 1'b1);
        req = 4'b0000;
        tick();
        expect_idle("wrap_idle");
        // ptr wrapped to 0: requester 0 beats requester 3.
        req = 4'b1001;
        tick();
        expect_grant("wrap_regrant", 2'd0, 1'b0);

        // Reset mid-grant during requester 2's third hold cycle.
        do_reset();
        req = 4'b0100;
        d   = 4'b0100;
        tick();
        tick();
        tick();
        check("mid_pre.gnt", gnt, 4'b0100);
        rst = 1'b1;
        tick();
        expect_idle("mid_rst");
        check("mid_rst.s", {2'b00, s}, 4'b0000);
        rst = 1'b0;
        tick();
        expect_grant("mid_regrant", 2'd2, 1'b1);
        req = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_hold.gnt", gnt, 4'b0100);
        end
        tick();
        expect_grant("mid_rotate", 2'd1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
